// File: rtl/jcontrol_seq_if.sv
// Handshake bundle between the clock/stepper block, the control sequencer and the datapath.
// The sequencer is the slave side; the clock/stepper + datapath side is the master.
interface jcontrol_seq_if;
    logic       cke;
    logic       cks;
    logic [5:0] step;
    logic [7:0] ir;
    logic [3:0] alu_flags;
    logic [3:0] en_reg;
    logic [3:0] set_reg;
    logic       en_ram;
    logic       set_ram;
    logic       set_mar;
    logic       en_iar;
    logic       set_iar;
    logic       set_ir;
    logic       en_acc;
    logic       set_acc;
    logic       set_tmp;
    logic       bus1;
    logic [2:0] alu_op;
    logic       carry_in;
    logic [3:0] flags;
    logic       err;

    modport master (
        output cke, cks, step, ir, alu_flags,
        input  en_reg, set_reg, en_ram, set_ram, set_mar, en_iar, set_iar, set_ir,
               en_acc, set_acc, set_tmp, bus1, alu_op, carry_in, flags, err
    );

    modport slave (
        input  cke, cks, step, ir, alu_flags,
        output en_reg, set_reg, en_ram, set_ram, set_mar, en_iar, set_iar, set_ir,
               en_acc, set_acc, set_tmp, bus1, alu_op, carry_in, flags, err
    );
endinterface

// File: rtl/jcontrol_seq.sv
// Step-driven control sequencer: decodes ir per stepper state into registered enable/set strobes.
// All strobes, flags and err are registered: valid exactly 1 clk after the sample that produced them.
module jcontrol_seq (
    input  logic             clk,
    input  logic             reset,
    jcontrol_seq_if.slave    ctl
);
    typedef enum logic [1:0] {PH_IDLE, PH_EN, PH_ES, PH_EN2} phase_e;

    typedef struct packed {
        logic [3:0] en_reg;
        logic [3:0] set_reg;
        logic       en_ram, set_ram, set_mar, en_iar, set_iar, set_ir;
        logic       en_acc, set_acc, set_tmp, bus1;
        logic [2:0] alu_op;
    } strb_t;

    phase_e     state_q, state_d;
    logic [5:0] step_q;
    logic       cks_q;
    logic       err_q, err_d;
    logic [3:0] flags_q, flags_d;
    strb_t      strb_q, strb_d, en_p, set_p;
    logic       viol, step_onehot, ok, cks_rise;
    logic [3:0] dec_a, dec_b;
    logic [2:0] op;

    assign op          = ctl.ir[6:4];
    assign dec_a       = 4'b0001 << ctl.ir[3:2];
    assign dec_b       = 4'b0001 << ctl.ir[1:0];
    assign step_onehot = (ctl.step != 6'd0) && ((ctl.step & (ctl.step - 6'd1)) == 6'd0);
    assign cks_rise    = ctl.cks && !cks_q;

    // Phase tracker and protocol checking; any violation kills this sample's strobes too.
    always_comb begin
        state_d = state_q;
        viol    = 1'b0;
        case ({ctl.cke, ctl.cks})
            2'b00: state_d = PH_IDLE;
            2'b10: state_d = (state_q == PH_ES || state_q == PH_EN2) ? PH_EN2 : PH_EN;
            2'b11: begin
                state_d = PH_ES;
                if (state_q != PH_EN && state_q != PH_ES) viol = 1'b1;
            end
            default: begin
                state_d = PH_IDLE;
                viol    = 1'b1;
            end
        endcase
        if (ctl.cke && !step_onehot) viol = 1'b1;
        if (state_q != PH_IDLE && ctl.step != step_q) viol = 1'b1;
        err_d = err_q | viol;
        ok    = !err_d;
    end

    always_comb begin
        en_p  = '0;
        set_p = '0;
        case (ctl.step)
            6'b000001: begin
                en_p.bus1 = 1'b1; en_p.en_iar = 1'b1; set_p.set_mar = 1'b1; set_p.set_acc = 1'b1;
            end
            6'b000010: begin en_p.en_ram = 1'b1; set_p.set_ir  = 1'b1; end
            6'b000100: begin en_p.en_acc = 1'b1; set_p.set_iar = 1'b1; end
            6'b001000: begin
                if (ctl.ir[7]) begin
                    en_p.en_reg = dec_b; set_p.set_tmp = 1'b1;
                end else begin
                    case (op)
                        3'd0, 3'd1: begin en_p.en_reg = dec_a; set_p.set_mar = 1'b1; end
                        3'd2, 3'd5: begin
                            en_p.bus1 = 1'b1; en_p.en_iar = 1'b1;
                            set_p.set_mar = 1'b1; set_p.set_acc = 1'b1;
                        end
                        3'd3: begin en_p.en_reg = dec_b; set_p.set_iar = 1'b1; end
                        3'd4: begin en_p.en_iar = 1'b1; set_p.set_mar = 1'b1; end
                        default: ;
                    endcase
                end
            end
            6'b010000: begin
                if (ctl.ir[7]) begin
                    en_p.en_reg = dec_a; en_p.alu_op = op; set_p.set_acc = 1'b1;
                end else begin
                    case (op)
                        3'd0, 3'd2: begin en_p.en_ram = 1'b1; set_p.set_reg = dec_b; end
                        3'd1: begin en_p.en_reg = dec_b; set_p.set_ram = 1'b1; end
                        3'd4: begin en_p.en_ram = 1'b1; set_p.set_iar = 1'b1; end
                        3'd5: begin en_p.en_acc = 1'b1; set_p.set_iar = 1'b1; end
                        default: ;
                    endcase
                end
            end
            6'b100000: begin
                if (ctl.ir[7]) begin
                    // CMP only updates flags; its result must not be written back.
                    if (op != 3'b111) begin en_p.en_acc = 1'b1; set_p.set_reg = dec_b; end
                end else if (op == 3'd2) begin
                    en_p.en_acc = 1'b1; set_p.set_iar = 1'b1;
                end else if (op == 3'd5 && (ctl.ir[3:0] & flags_q) != 4'd0) begin
                    en_p.en_ram = 1'b1; set_p.set_iar = 1'b1;
                end
            end
            default: ;
        endcase

        strb_d = '0;
        if (ok) begin
            if (ctl.cke) strb_d = strb_d | en_p;
            if (ctl.cks) strb_d = strb_d | set_p;
        end

        flags_d = flags_q;
        if (ok && cks_rise) begin
            if (ctl.ir[7] && ctl.step == 6'b010000)
                flags_d = ctl.alu_flags;
            else if (ctl.ir[7:4] == 4'b0110 && ctl.step == 6'b001000)
                flags_d = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PH_IDLE;
            step_q  <= 6'd0;
            cks_q   <= 1'b0;
            err_q   <= 1'b0;
            flags_q <= 4'd0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= ctl.step;
            cks_q   <= ctl.cks;
            err_q   <= err_d;
            flags_q <= flags_d;
            strb_q  <= strb_d;
        end
    end

    assign ctl.en_reg   = strb_q.en_reg;
    assign ctl.set_reg  = strb_q.set_reg;
    assign ctl.en_ram   = strb_q.en_ram;
    assign ctl.set_ram  = strb_q.set_ram;
    assign ctl.set_mar  = strb_q.set_mar;
    assign ctl.en_iar   = strb_q.en_iar;
    assign ctl.set_iar  = strb_q.set_iar;
    assign ctl.set_ir   = strb_q.set_ir;
    assign ctl.en_acc   = strb_q.en_acc;
    assign ctl.set_acc  = strb_q.set_acc;
    assign ctl.set_tmp  = strb_q.set_tmp;
    assign ctl.bus1     = strb_q.bus1;
    assign ctl.alu_op   = strb_q.alu_op;
    assign ctl.flags    = flags_q;
    assign ctl.carry_in = flags_q[3];
    assign ctl.err      = err_q;
endmodule

// File: tb/tb_jcontrol_seq.sv
// Directed bench for jcontrol_seq: expected strobe/flag/err vectors are queued per sample and checked 1 clk later.
module tb_jcontrol_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    jcontrol_seq_if bus ();
    jcontrol_seq dut (.clk(clk), .reset(reset), .ctl(bus));

    typedef struct packed {
        logic [3:0] en_reg;
        logic [3:0] set_reg;
        logic [9:0] bits;   // {en_ram,set_ram,set_mar,en_iar,set_iar,set_ir,en_acc,set_acc,set_tmp,bus1}
        logic [2:0] alu_op;
    } strb_t;

    typedef struct packed {
        strb_t      s;
        logic [3:0] flags;
        logic       carry;
        logic       err;
    } obs_t;

    localparam logic [9:0] EN_RAM = 10'b1000000000, SET_RAM = 10'b0100000000,
                           SET_MAR = 10'b0010000000, EN_IAR = 10'b0001000000,
                           SET_IAR = 10'b0000100000, SET_IR = 10'b0000010000,
                           EN_ACC = 10'b0000001000, SET_ACC = 10'b0000000100,
                           SET_TMP = 10'b0000000010, BUS1 = 10'b0000000001;
    localparam strb_t Z = '0;

    obs_t       sb_q[$];
    int         tests = 0;
    int         fails = 0;
    logic [3:0] exp_flags;
    logic       exp_err;

    function automatic strb_t mk(logic [3:0] er, logic [3:0] sr, logic [9:0] b, logic [2:0] op);
        mk = {er, sr, b, op};
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.s = {bus.en_reg, bus.set_reg, bus.en_ram, bus.set_ram, bus.set_mar, bus.en_iar,
               bus.set_iar, bus.set_ir, bus.en_acc, bus.set_acc, bus.set_tmp, bus.bus1, bus.alu_op};
        o.flags = bus.flags;
        o.carry = bus.carry_in;
        o.err   = bus.err;
        return o;
    endfunction

    task automatic drive(logic ke, logic ks);
        bus.cke = ke;
        bus.cks = ks;
    endtask

    task automatic tick(string tag, strb_t es);
        obs_t e, o;
        e.s     = es;
        e.flags = exp_flags;
        e.carry = exp_flags[3];
        e.err   = exp_err;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        o = observe();
        e = sb_q.pop_front();
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // One legal 4-phase window for a step; cks held for 'hold' clks, alu_flags flipped after the first set sample.
    task automatic run_step(string tag, int s, logic [7:0] irv, strb_t enp, strb_t setp,
                            logic [3:0] af, logic cap, logic clf, int hold);
        bus.ir        = irv;
        bus.alu_flags = af;
        bus.step      = 6'b000001 << (s - 1);
        drive(1'b0, 1'b0); tick({tag, "/idle"}, Z);
        drive(1'b1, 1'b0); tick({tag, "/en"}, enp);
        for (int i = 0; i < hold; i++) begin
            drive(1'b1, 1'b1);
            if (i == 0 && cap) exp_flags = af;
            if (i == 0 && clf) exp_flags = 4'b0000;
            tick($sformatf("%s/es%0d", tag, i), enp | setp);
            bus.alu_flags = ~af;
        end
        drive(1'b1, 1'b0); tick({tag, "/en2"}, enp);
        drive(1'b0, 1'b0); tick({tag, "/idle2"}, Z);
    endtask

    task automatic do_reset(string tag);
        reset = 1'b1;
        drive(1'b0, 1'b0);
        exp_err   = 1'b0;
        exp_flags = 4'b0000;
        tick({tag, "/rst"}, Z);
        reset = 1'b0;
        tick({tag, "/rel"}, Z);
    endtask

    initial begin
        reset = 1'b1;
        bus.cke = 1'b0; bus.cks = 1'b0; bus.step = 6'b000001; bus.ir = 8'h00; bus.alu_flags = 4'h0;
        exp_flags = 4'b0000;
        exp_err   = 1'b0;
        tick("reset0", Z);
        tick("reset1", Z);
        reset = 1'b0;
        tick("release", Z);

        // Fetch + ADD R1,R2
        run_step("add_s1", 1, 8'h86, mk(0, 0, BUS1 | EN_IAR, 0), mk(0, 0, SET_MAR | SET_ACC, 0), 4'h0, 0, 0, 1);
        run_step("add_s2", 2, 8'h86, mk(0, 0, EN_RAM, 0), mk(0, 0, SET_IR, 0), 4'h0, 0, 0, 1);
        run_step("add_s3", 3, 8'h86, mk(0, 0, EN_ACC, 0), mk(0, 0, SET_IAR, 0), 4'h0, 0, 0, 1);
        run_step("add_s4", 4, 8'h86, mk(4'b0100, 0, 0, 0), mk(0, 0, SET_TMP, 0), 4'h0, 0, 0, 1);
        run_step("add_s5", 5, 8'h86, mk(4'b0010, 0, 0, 3'b000), mk(0, 0, SET_ACC, 0), 4'b0001, 1, 0, 2);
        run_step("add_s6", 6, 8'h86, mk(0, 0, EN_ACC, 0), mk(0, 4'b0100, 0, 0), 4'h0, 0, 0, 1);

        // ALU op 011, a=R3, b=R1; flags with C set drives carry_in
        run_step("op3_s4", 4, 8'hBD, mk(4'b0010, 0, 0, 0), mk(0, 0, SET_TMP, 0), 4'h0, 0, 0, 1);
        run_step("op3_s5", 5, 8'hBD, mk(4'b1000, 0, 0, 3'b011), mk(0, 0, SET_ACC, 0), 4'b1100, 1, 0, 3);
        run_step("op3_s6", 6, 8'hBD, mk(0, 0, EN_ACC, 0), mk(0, 4'b0010, 0, 0), 4'h0, 0, 0, 1);

        // CMP R0,R1: flags only, s6 silent
        run_step("cmp_s4", 4, 8'hF1, mk(4'b0010, 0, 0, 0), mk(0, 0, SET_TMP, 0), 4'h0, 0, 0, 1);
        run_step("cmp_s5", 5, 8'hF1, mk(4'b0001, 0, 0, 3'b111), mk(0, 0, SET_ACC, 0), 4'b0010, 1, 0, 1);
        run_step("cmp_s6", 6, 8'hF1, Z, Z, 4'h0, 0, 0, 1);

        // JMPIF mask E: taken with flags=0010, not taken with flags=0001
        run_step("jif_s4", 4, 8'h52, mk(0, 0, BUS1 | EN_IAR, 0), mk(0, 0, SET_MAR | SET_ACC, 0), 4'h0, 0, 0, 1);
        run_step("jif_s5", 5, 8'h52, mk(0, 0, EN_ACC, 0), mk(0, 0, SET_IAR, 0), 4'h0, 0, 0, 1);
        run_step("jif_s6t", 6, 8'h52, mk(0, 0, EN_RAM, 0), mk(0, 0, SET_IAR, 0), 4'h0, 0, 0, 1);
        run_step("flg_z", 5, 8'hF1, mk(4'b0001, 0, 0, 3'b111), mk(0, 0, SET_ACC, 0), 4'b0001, 1, 0, 1);
        run_step("jif_s6n", 6, 8'h52, Z, Z, 4'h0, 0, 0, 1);

        // CLF after flags=1111, cks held 3 clks
        run_step("flg_all", 5, 8'hF1, mk(4'b0001, 0, 0, 3'b111), mk(0, 0, SET_ACC, 0), 4'b1111, 1, 0, 1);
        run_step("clf_s4", 4, 8'h60, Z, Z, 4'h0, 0, 1, 3);

        // Remaining opcodes
        run_step("st_s4", 4, 8'h1B, mk(4'b0100, 0, 0, 0), mk(0, 0, SET_MAR, 0), 4'h0, 0, 0, 1);
        run_step("st_s5", 5, 8'h1B, mk(4'b1000, 0, 0, 0), mk(0, 0, SET_RAM, 0), 4'h0, 0, 0, 1);
        run_step("jmpr_s4", 4, 8'h32, mk(4'b0100, 0, 0, 0), mk(0, 0, SET_IAR, 0), 4'h0, 0, 0, 1);
        run_step("jmp_s5", 5, 8'h40, mk(0, 0, EN_RAM, 0), mk(0, 0, SET_IAR, 0), 4'h0, 0, 0, 1);
        run_step("data_s5", 5, 8'h21, mk(0, 0, EN_RAM, 0), mk(0, 4'b0010, 0, 0), 4'h0, 0, 0, 1);
        run_step("data_s6", 6, 8'h21, mk(0, 0, EN_ACC, 0), mk(0, 0, SET_IAR, 0), 4'h0, 0, 0, 1);
        run_step("nop_s5", 5, 8'h70, Z, Z, 4'h0, 0, 0, 1);

        // LOAD with reset in the middle of s5
        run_step("ld_s4", 4, 8'h06, mk(4'b0010, 0, 0, 0), mk(0, 0, SET_MAR, 0), 4'h0, 0, 0, 1);
        bus.step = 6'b010000;
        drive(1'b0, 1'b0); tick("ld_s5/idle", Z);
        drive(1'b1, 1'b0); tick("ld_s5/en", mk(0, 0, EN_RAM, 0));
        drive(1'b1, 1'b1); tick("ld_s5/es", mk(0, 4'b0100, EN_RAM, 0));
        reset = 1'b1;
        tick("ld_s5/rst_mid", Z);
        drive(1'b0, 1'b0); tick("ld_s5/rst_hold", Z);
        reset = 1'b0;
        tick("ld_s5/rel", Z);
        run_step("refetch_s1", 1, 8'h06, mk(0, 0, BUS1 | EN_IAR, 0), mk(0, 0, SET_MAR | SET_ACC, 0), 4'h0, 0, 0, 1);

        // cks without cke: sticky err, strobes dead afterwards
        bus.step = 6'b000001;
        drive(1'b0, 1'b1);
        exp_err = 1'b1;
        tick("f_cks_only", Z);
        run_step("f_dead_s5", 5, 8'h86, Z, Z, 4'b1111, 0, 0, 1);
        do_reset("f1");

        // step not one-hot while cke=1
        bus.step = 6'b000011;
        drive(1'b0, 1'b0); tick("f_mh/idle", Z);
        drive(1'b1, 1'b0);
        exp_err = 1'b1;
        tick("f_multihot", Z);
        do_reset("f2");

        // ES entered straight from IDLE
        bus.step = 6'b000001;
        drive(1'b0, 1'b0); tick("f_es/idle", Z);
        drive(1'b1, 1'b1);
        exp_err = 1'b1;
        tick("f_es_from_idle", Z);
        do_reset("f3");

        // step changing inside the enable window
        bus.step = 6'b000010;
        drive(1'b0, 1'b0); tick("f_sc/idle", Z);
        drive(1'b1, 1'b0); tick("f_sc/en", mk(0, 0, EN_RAM, 0));
        bus.step = 6'b000100;
        exp_err = 1'b1;
        tick("f_step_change", Z);
        do_reset("f4");

        run_step("final_s2", 2, 8'h00, mk(0, 0, EN_RAM, 0), mk(0, 0, SET_IR, 0), 4'h0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/jcontrol_seq.md
# jcontrol_seq

Step-driven control sequencer: the consumer of the clock-phase strobes (enable/set) and the one-hot stepper outputs. It decodes the instruction register per step and drives registered enable/set strobes for the register file, RAM, MAR, IAR, IR, ACC, TMP, bus1 and the ALU. It owns the flags register and the JMPIF condition test. It flags phase-protocol violations from the clock/stepper side. It sits between the clock/stepper block and the datapath of the 8-bit CPU.

## Interface
- No parameters; all widths are fixed by the 8-bit ISA.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- cke  in  1  enable-phase level from the clock block (sampled each clk).
- cks  in  1  set-phase level from the clock block (sampled each clk).
- step  in  6  one-hot stepper state; step[0] = step 1 … step[5] = step 6.
- ir  in  8  instruction register contents.
- alu_flags  in  4  ALU flag outputs {C,A,E,Z}.
- en_reg / set_reg  out  4  one-hot general-register enable / set (R0..R3).
- en_ram, set_ram, set_mar, en_iar, set_iar, set_ir, en_acc, set_acc, set_tmp, bus1  out  1 each.
- alu_op  out  3  ALU operation; 000 (ADD) when idle.
- carry_in  out  1  equals flags[C].
- flags  out  4  flags register {C,A,E,Z}.
- err  out  1  sticky protocol-violation flag.

## Operation
- Input sampling: cke, cks, step and ir are sampled each clk.
  - All strobes are computed from these samples and registered.
  - Enables assert only while sampled cke=1.
  - Sets assert only while sampled cks=1.
  - bus1 and alu_op follow the step decode and are gated by cke.
- Fetch, for every instruction:
  - s1: bus1, en_iar, set_mar, set_acc.
  - s2: en_ram, set_ir.
  - s3: en_acc, set_iar.
- ALU instruction (ir[7]=1), with op=ir[6:4], a=ir[3:2], b=ir[1:0]:
  - s4: en_reg[b], set_tmp.
  - s5: en_reg[a], alu_op=op, set_acc; the flags register captures alu_flags.
  - s6: en_acc, set_reg[b]. CMP (op=111) suppresses s6 entirely.
- Other instructions, decoded on ir[7:4]:
  - 0000 LOAD: s4 en_reg[a], set_mar; s5 en_ram, set_reg[b].
  - 0001 STORE: s4 en_reg[a], set_mar; s5 en_reg[b], set_ram.
  - 0010 DATA: s4 bus1, en_iar, set_mar, set_acc; s5 en_ram, set_reg[b]; s6 en_acc, set_iar.
  - 0011 JMPR: s4 en_reg[b], set_iar.
  - 0100 JMP: s4 en_iar, set_mar; s5 en_ram, set_iar.
  - 0101 JMPIF, mask=ir[3:0] over {C,A,E,Z}:
    - s4 bus1, en_iar, set_mar, set_acc; s5 en_acc, set_iar.
    - s6 en_ram, set_iar only if (mask & flags) != 0.
  - 0110 CLF: at s4 set phase, flags cleared to 0000.
  - 0111: no action in s4–s6.
- Flags capture: flags change only on the first clk where sampled cks rises during s5 of an ALU instruction, or s4 of CLF. Holding cks for several clks captures once.
- Phase tracker FSM, state advanced on sampled (cke,cks):
  - IDLE(00) → EN(10) → ES(11) → EN2(10) → IDLE(00).
  - Staying in a state is legal.
- err is set (sticky until reset) on any of:
  - cks=1 while cke=0;
  - ES entered from any state other than EN;
  - step not one-hot (zero or multiple bits) while cke=1;
  - step changing while in EN, ES or EN2.
- Error handling: on err, all strobes are forced low from the next clk and stay low until reset.

## Timing
- Latency: every strobe is valid exactly 1 clk after the sample that produced it. Deassertion also follows 1 clk after cke/cks fall.
- Phase ordering: set strobes are nested inside enable strobes when the clock block obeys the protocol (cks window strictly within cke window).
- Reset values:
  - All strobes 0, alu_op=000, flags=0000, carry_in=0, err=0, FSM=IDLE.
  - Reset asserted mid-step drops all strobes on the next clk.
  - After reset release, nothing asserts until a fresh IDLE→EN transition is sampled.
- Flags timing:
  - The flags update is visible on the flags port 1 clk after the capturing sample.
  - JMPIF s6 uses the flags value held at its own s6 sample.

## Test plan
- Fetch + ADD R1,R2 (ir=8'b1000_0110) with a legal 4-phase sequence per step:
  - s4: en_reg=0100, set_tmp.
  - s5: en_reg=0010, alu_op=000, set_acc.
  - s6: set_reg=0100.
  - set_* strobes appear only inside cks windows, 1 clk late.
- CMP (ir=8'hF1) with alu_flags=0010 → flags=0010 after s5; no strobe in s6.
- JMPIF with ir=8'h52 (mask E):
  - flags=0010 → s6 asserts en_ram and set_iar.
  - flags=0001 → s6 is silent.
- CLF after flags=1111:
  - flags=0000 one clk after the s4 set sample.
  - cks held 3 clks → captures once, no glitch.
- Protocol faults:
  - cks=1 with cke=0 → err=1 next clk, all strobes 0 thereafter.
  - step=6'b000011 with cke=1 → err=1.
- Reset during s5 of LOAD → all outputs 0 next clk; a new s1 fetch then executes normally with err=0.
